// File: rtl/uart_tx_arbiter_if.sv
// Requester / TX-core signal bundle for uart_tx_arbiter.
// The master modport is the arbiter; the slave modport is the client and TX-core side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [IW-1:0]             grant_id;
  logic                      arb_busy;
  logic                      done_pulse;
  logic                      err_pulse;

  modport master (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ack, tx_start, tx_data, grant_id, arb_busy, done_pulse, err_pulse
  );

  modport slave (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ack, tx_start, tx_data, grant_id, arb_busy, done_pulse, err_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NUM_REQ byte requesters.
// Optional START/BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       winner;
  logic                found;
  logic                armed;
  logic                timeout;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   data_q;
  logic [IW-1:0]       grant_q;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == IW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Scan from the farthest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_index(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = rr_index(rr_ptr, k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = START;
      START:   if (timeout) state_nxt = IDLE;
               else if (bus.tx_busy) state_nxt = BUSY;
      BUSY:    if (timeout) state_nxt = IDLE;
               else if (armed && bus.tx_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      armed   <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= '0;
      if (state == IDLE && found) begin
        data_q  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
        grant_q <= winner;
        ack_q   <= NUM_REQ'(1) << winner;
      end
      // tx_done must be seen low inside BUSY before a high sample counts as completion.
      if (state != BUSY)    armed <= 1'b0;
      else if (!bus.tx_done) armed <= 1'b1;
      if (state == DONE || timeout) rr_ptr <= next_id(grant_q);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state == IDLE) tmo_cnt <= '0;
      else if (state == START || state == BUSY) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout       = (state == START || state == BUSY) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus.err_pulse = err_q;
`else
  assign timeout       = 1'b0;
  assign bus.err_pulse = 1'b0;
`endif

  assign bus.req_ack    = ack_q;
  assign bus.tx_data    = data_q;
  assign bus.grant_id   = grant_q;
  assign bus.tx_start   = (state == START);
  assign bus.arb_busy   = (state != IDLE);
  assign bus.done_pulse = (state == DONE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus randomized transfers
// checked against a round-robin model; timeout step depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;
  logic [NUM_REQ-1:0] pend;
  logic [DATA_W-1:0]  dat [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive_req();
    bus.req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = dat[i];
  endtask

  // Entered and left at a negedge with the DUT in IDLE. mode: 0 normal,
  // 1 tx_done already high on BUSY entry, 2 reset asserted in BUSY.
  task automatic transfer(input string tag, input int busy_dly, input int done_dly,
                          input int mode, output int w);
    logic [DATA_W-1:0] exp_d;
    drive_req();
    w = pick(pend, rr_m);
    exp_d = dat[w];
    @(negedge clk);
    check({tag, "_ack"},   32'(bus.req_ack), 32'(1 << w));
    check({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_data"},  32'(bus.tx_data), 32'(exp_d));
    check({tag, "_grant"}, 32'(bus.grant_id), 32'(w));
    check({tag, "_busy"},  32'(bus.arb_busy), 32'd1);
    pend[w] = 1'b0;
    drive_req();
    for (int i = 0; i < busy_dly; i++) begin
      @(negedge clk);
      check({tag, "_start_hold"}, 32'(bus.tx_start), 32'd1);
      check({tag, "_data_hold"},  32'(bus.tx_data), 32'(exp_d));
    end
    bus.tx_busy = 1'b1;
    if (mode == 1) bus.tx_done = 1'b1;
    @(negedge clk);
    check({tag, "_start_drop"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_ack_once"},   32'(bus.req_ack), 32'd0);
    check({tag, "_in_busy"},    32'(bus.arb_busy), 32'd1);
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      check({tag, "_rst_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_rst_busy"},  32'(bus.arb_busy), 32'd0);
      check({tag, "_rst_done"},  32'(bus.done_pulse), 32'd0);
      check({tag, "_rst_grant"}, 32'(bus.grant_id), 32'd0);
      check({tag, "_rst_data"},  32'(bus.tx_data), 32'd0);
      rst = 1'b0;
      bus.tx_busy = 1'b0;
      rr_m = 0;
      @(negedge clk);
      check({tag, "_rst_nodone"}, 32'(bus.done_pulse), 32'd0);
      return;
    end
    if (mode == 1) begin
      repeat (3) begin
        @(negedge clk);
        check({tag, "_early_done"}, 32'(bus.done_pulse), 32'd0);
        check({tag, "_still_busy"}, 32'(bus.arb_busy), 32'd1);
      end
      bus.tx_done = 1'b0;
    end
    for (int i = 0; i < done_dly; i++) begin
      @(negedge clk);
      check({tag, "_no_done"},     32'(bus.done_pulse), 32'd0);
      check({tag, "_data_busy"},   32'(bus.tx_data), 32'(exp_d));
    end
    bus.tx_done = 1'b1;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.done_pulse), 32'd1);
    bus.tx_done = 1'b0;
    @(negedge clk);
    check({tag, "_done_once"}, 32'(bus.done_pulse), 32'd0);
    check({tag, "_idle"},      32'(bus.arb_busy), 32'd0);
    rr_m = (w + 1) % NUM_REQ;
  endtask

  initial begin
    int w;
    int cnt;
    logic [NUM_REQ-1:0] fresh;
    logic [NUM_REQ-1:0] keep;
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;
    drive_req();
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(bus.arb_busy), 32'd0);
    check("rst_start", 32'(bus.tx_start), 32'd0);
    check("rst_ack",   32'(bus.req_ack), 32'd0);
    check("rst_data",  32'(bus.tx_data), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_done",  32'(bus.done_pulse), 32'd0);
    check("rst_err",   32'(bus.err_pulse), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", 32'(bus.arb_busy), 32'd0);

    // Single requester 2 with 0xA5; leaves the pointer at 3.
    pend = 4'b0100;
    dat[2] = 8'hA5;
    transfer("t1", 3, 20, 0, w);

    // Pointer 3, requesters 0 and 1: wrap to 0 then 1.
    pend = 4'b0011;
    dat[0] = 8'(($urandom));
    dat[1] = 8'(($urandom));
    transfer("wrap0", 1, 2, 0, w);
    transfer("wrap1", 0, 1, 0, w);

    // tx_done high on BUSY entry must wait for a fall and a new rise.
    pend = 4'b0001;
    dat[0] = 8'h3C;
    transfer("prehi", 2, 2, 1, w);

    // Reset in BUSY; pointer returns to 0 afterwards.
    pend = 4'b0100;
    dat[2] = 8'h5A;
    transfer("rstbusy", 1, 0, 2, w);

    // Continuous requests from all: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'(8'h10 * i + 1);
    for (int n = 0; n < 8; n++) begin
      pend = 4'b1111;
      transfer("fair", n % 3, 1 + n % 2, 0, w);
    end
    pend = '0;
    drive_req();

    // Random request sets, drops before ack, and core timing.
    for (int n = 0; n < 40; n++) begin
      keep  = 4'($urandom);
      fresh = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++)
        if (fresh[i] && !pend[i]) dat[i] = 8'($urandom);
      pend = (pend & keep) | fresh;
      if (pend == '0) begin
        cnt = $urandom_range(0, NUM_REQ - 1);
        pend[cnt] = 1'b1;
        dat[cnt] = 8'($urandom);
      end
      transfer("rand", $urandom_range(0, 5), $urandom_range(1, 6),
               ($urandom_range(0, 7) == 0) ? 1 : 0, w);
    end
    pend = '0;
    drive_req();
    @(negedge clk);

    // Core never reports busy.
    pend = 4'b0010;
    dat[1] = 8'hE7;
    drive_req();
    w = pick(pend, rr_m);
    @(negedge clk);
    check("tmo_ack", 32'(bus.req_ack), 32'(1 << w));
    pend = '0;
    drive_req();
`ifdef UART_ARB_TIMEOUT_EN
    cnt = 1;
    for (int i = 0; i < 100 && bus.tx_start; i++) begin
      @(negedge clk);
      if (bus.tx_start) cnt++;
    end
    check("tmo_len",    32'(cnt), 32'(TMO));
    check("tmo_err",    32'(bus.err_pulse), 32'd1);
    check("tmo_idle",   32'(bus.arb_busy), 32'd0);
    check("tmo_nodone", 32'(bus.done_pulse), 32'd0);
    @(negedge clk);
    check("tmo_err_once", 32'(bus.err_pulse), 32'd0);
`else
    cnt = 0;
    repeat (TMO + 20) begin
      @(negedge clk);
      if (bus.arb_busy && bus.tx_start && !bus.err_pulse) cnt++;
    end
    check("wait_forever", 32'(cnt), 32'(TMO + 20));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
